ps2_key_event_fifo: RTL and testbench

Downstream stage of the PS/2 scancode receiver: consumes the raw received-byte stream, decodes the E0 (extended), F0 (break) and E1 (Pause) prefix sequences into single key events, and buffers them in a FIFO. The CPU reads the events through a memory-mapped slave port with an interrupt. This replaces polling the raw last-byte register and prevents lost keystrokes.

---
 rtl/ps2_key_event_fifo.sv | 241 ++++++++++++++++++++++++
 tb/tb_ps2_key_event_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_fifo.sv
// ---------------------------------------------------------------------------
// ps2_key_event_fifo
//
// Purpose : Turns the raw PS/2 scancode byte stream into single key events.
//           E0 (extended), F0 (break) and E1 (Pause) prefixes are decoded into
//           an 11-bit event {ctrl, break, ext, code}. Events are buffered in a
//           FIFO, and the CPU reads them through a small slave port. The port
//           raises a level interrupt while events are pending.
//
// Optional feature macro: PS2KEY_PAUSE_FILTER_EN
//           Defined     : the 8-byte Pause sequence (E1 + 7 bytes) collapses
//                         into one event {0,0,1,E1}.
//           Not defined : E1 is an ordinary code.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   byte_valid   in   one-cycle strobe; byte_data holds a new scancode byte
//   byte_data    in   [7:0] received scancode byte
//   s_cs_n       in   slave chip select, active low
//   s_address    in   0 = EVENT (read pops), 1 = STATUS / CTRL
//   s_read       in   read strobe
//   s_write      in   write strobe
//   s_writedata  in   [31:0] CTRL write data:
//                     [31] flush, [16] irq_en, [2] clear overflow
//   s_readdata   out  [31:0] read data
//                     EVENT  = {valid, 20'b0, event}
//                     STATUS = {irq_en@16, count@15:8, ovf@2, full@1, empty@0}
//   irq          out  registered level interrupt = irq_en & ~empty
// ---------------------------------------------------------------------------
module ps2_key_event_fifo #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        s_cs_n,
   input  logic        s_address,
   input  logic        s_read,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic        irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   C_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GOT_E0   = 3'd1,
      ST_GOT_F0   = 3'd2,
      ST_GOT_E0F0 = 3'd3,
      ST_SKIP_E1  = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_push;
   logic [10:0]           w_push_evt;
   logic                  w_is_ctrl;
   logic [10:0]           r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_overflow;
   logic                  r_irq_en;
   logic                  r_irq;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_ctrl_wr;
   logic                  w_flush;
   logic                  w_push_ok;
   logic                  w_unused;
`ifdef PS2KEY_PAUSE_FILTER_EN
   logic [2:0]            r_skip_cnt;
   logic [2:0]            w_skip_nxt;
`endif

   assign w_empty   = (r_count == {(DEPTH_LOG2+1){1'b0}});
   assign w_full    = (r_count == C_FULL);
   assign w_pop     = ~s_cs_n & s_read & ~s_address & ~w_empty;
   assign w_ctrl_wr = ~s_cs_n & s_write & s_address;
   assign w_flush   = w_ctrl_wr & s_writedata[31];
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign w_push_ok = w_push & (~w_full | w_pop) & ~w_flush;
   assign w_unused  = ^{s_writedata[30:17], s_writedata[15:3], s_writedata[1:0]};
   assign irq       = r_irq;

   // Classify link-level control bytes (BAT, ACK, echo, resend, errors).
   always_comb begin
      case (byte_data)
         8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: w_is_ctrl = 1'b1;
         default:                                         w_is_ctrl = 1'b0;
      endcase
   end

   // Decoder next-state and event generation; acts only on byte_valid cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_push_evt  = 11'h000;
`ifdef PS2KEY_PAUSE_FILTER_EN
      w_skip_nxt  = r_skip_cnt;
`endif
      if (byte_valid) begin
`ifdef PS2KEY_PAUSE_FILTER_EN
         // Inside the Pause sequence everything, control bytes included, is swallowed.
         if (r_state == ST_SKIP_E1) begin
            if (r_skip_cnt == 3'd1) begin
               w_push      = 1'b1;
               w_push_evt  = {1'b0, 1'b0, 1'b1, 8'hE1};
               w_state_nxt = ST_IDLE;
               w_skip_nxt  = 3'd0;
            end else begin
               w_skip_nxt  = r_skip_cnt - 3'd1;
            end
         end else
`endif
         if (w_is_ctrl) begin
            w_push      = 1'b1;
            w_push_evt  = {1'b1, 1'b0, 1'b0, byte_data};
            w_state_nxt = ST_IDLE;
         end else if (byte_data == 8'hE0) begin
            // Redundant E0 after any prefix is absorbed.
            if (r_state == ST_IDLE) begin
               w_state_nxt = ST_GOT_E0;
            end else begin
               w_state_nxt = r_state;
            end
         end else if (byte_data == 8'hF0) begin
            case (r_state)
               ST_IDLE:   w_state_nxt = ST_GOT_F0;
               ST_GOT_E0: w_state_nxt = ST_GOT_E0F0;
               default:   w_state_nxt = r_state;
            endcase
`ifdef PS2KEY_PAUSE_FILTER_EN
         end else if ((byte_data == 8'hE1) && (r_state == ST_IDLE)) begin
            w_state_nxt = ST_SKIP_E1;
            w_skip_nxt  = 3'd7;
`endif
         end else begin
            w_push      = 1'b1;
            w_push_evt  = {1'b0,
                           (r_state == ST_GOT_F0) || (r_state == ST_GOT_E0F0),
                           (r_state == ST_GOT_E0) || (r_state == ST_GOT_E0F0),
                           byte_data};
            w_state_nxt = ST_IDLE;
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Decoder state register; a flush abandons any partial prefix.
   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifdef PS2KEY_PAUSE_FILTER_EN
   // Pause-sequence byte counter.
   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_skip_cnt <= 3'd0;
      end else begin
         r_skip_cnt <= w_skip_nxt;
      end
   end
`endif

   // Event storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= w_push_evt;
      end
   end

   // FIFO pointers and occupancy; flush has priority over push and pop.
   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_wr_ptr <= {DEPTH_LOG2{1'b0}};
         r_rd_ptr <= {DEPTH_LOG2{1'b0}};
         r_count  <= {(DEPTH_LOG2+1){1'b0}};
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow, interrupt enable and registered interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
         r_irq_en   <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         // A new drop outranks a clear in the same cycle so it is never lost.
         if (w_push && w_full && !w_pop && !w_flush) begin
            r_overflow <= 1'b1;
         end else if (w_ctrl_wr && s_writedata[2]) begin
            r_overflow <= 1'b0;
         end
         if (w_ctrl_wr) begin
            r_irq_en <= s_writedata[16];
         end
         r_irq <= r_irq_en & ~w_empty;
      end
   end

   // Read-data mux over registered state.
   always_comb begin
      s_readdata = 32'h0000_0000;
      if (s_address == 1'b0) begin
         if (!w_empty) begin
            s_readdata = {1'b1, 20'h0_0000, r_mem[r_rd_ptr]};
         end else begin
            s_readdata = 32'h0000_0000;
         end
      end else begin
         s_readdata[0]                 = w_empty;
         s_readdata[1]                 = w_full;
         s_readdata[2]                 = r_overflow;
         s_readdata[8 +: DEPTH_LOG2+1] = r_count;
         s_readdata[16]                = r_irq_en;
      end
   end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
module tb_ps2_key_event_fifo;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        s_cs_n = 1'b1;
   logic        s_address = 1'b0;
   logic        s_read = 1'b0;
   logic        s_write = 1'b0;
   logic [31:0] s_writedata = 32'h0;
   logic [31:0] s_readdata;
   logic        irq;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   ps2_key_event_fifo #(.DEPTH_LOG2(3)) dut (
      .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
      .s_cs_n(s_cs_n), .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic read_event(output logic [31:0] d);
      @(negedge clk);
      s_cs_n = 1'b0; s_read = 1'b1; s_address = 1'b0;
      #1 d = s_readdata;
      @(negedge clk);
      s_cs_n = 1'b1; s_read = 1'b0;
   endtask

   task automatic read_status(output logic [31:0] d);
      @(negedge clk);
      s_address = 1'b1;
      #1 d = s_readdata;
   endtask

   task automatic write_ctrl(input logic [31:0] w);
      @(negedge clk);
      s_cs_n = 1'b0; s_write = 1'b1; s_address = 1'b1; s_writedata = w;
      @(negedge clk);
      s_cs_n = 1'b1; s_write = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      @(negedge clk); s_address = 1'b0; #1 d = s_readdata;
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_event got=%h exp=00000000", d); end
      read_status(d);
      checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=00000001", d); end
   endtask

   task automatic test_single();
      logic [31:0] d;
      write_ctrl(32'h0001_0000);
      send_byte(8'h1C);
      exp_q.push_back(32'h8000_001C);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_latency got=%b exp=0", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
      while (exp_q.size() > 0) begin
         read_event(d);
         checks++;
         if (d !== exp_q[0]) begin failures++; $display("FAIL single_event got=%h exp=%h", d, exp_q[0]); end
         void'(exp_q.pop_front());
      end
      read_event(d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL empty_read got=%h exp=00000000", d); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
   endtask

   task automatic test_ext_break();
      logic [31:0] d;
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      exp_q.push_back(32'h8000_0375);
      read_status(d);
      checks++;
      if (d !== 32'h0001_0100) begin failures++; $display("FAIL ext_break_status got=%h exp=00010100", d); end
      while (exp_q.size() > 0) begin
         read_event(d);
         checks++;
         if (d !== exp_q[0]) begin failures++; $display("FAIL ext_break_event got=%h exp=%h", d, exp_q[0]); end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      write_ctrl(32'h0001_0000);
      for (int i = 0; i < 8; i++) begin
         send_byte(8'h15);
         exp_q.push_back(32'h8000_0015);
      end
      send_byte(8'h16);
      read_status(d);
      checks++;
      if (d !== 32'h0001_0806) begin failures++; $display("FAIL overflow_status got=%h exp=00010806", d); end
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL overflow_irq got=%b exp=1", irq); end
      write_ctrl(32'h0000_0004);
      read_status(d);
      checks++;
      if (d !== 32'h0000_0802) begin failures++; $display("FAIL overflow_clear got=%h exp=00000802", d); end
   endtask

   task automatic test_pop_push_full();
      logic [31:0] d;
      @(negedge clk);
      s_cs_n = 1'b0; s_read = 1'b1; s_address = 1'b0;
      byte_valid = 1'b1; byte_data = 8'h2B;
      #1 d = s_readdata;
      exp_q.push_back(32'h8000_002B);
      @(negedge clk);
      s_cs_n = 1'b1; s_read = 1'b0; byte_valid = 1'b0;
      checks++;
      if (d !== exp_q[0]) begin failures++; $display("FAIL popush_head got=%h exp=%h", d, exp_q[0]); end
      void'(exp_q.pop_front());
      read_status(d);
      checks++;
      if (d !== 32'h0000_0802) begin failures++; $display("FAIL popush_status got=%h exp=00000802", d); end
      while (exp_q.size() > 0) begin
         read_event(d);
         checks++;
         if (d !== exp_q[0]) begin failures++; $display("FAIL popush_drain got=%h exp=%h", d, exp_q[0]); end
         void'(exp_q.pop_front());
      end
      read_status(d);
      checks++;
      if (d !== 32'h0000_0001) begin failures++; $display("FAIL popush_empty got=%h exp=00000001", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      send_byte(8'hFA);
      send_byte(8'hE0);
      do_reset();
      send_byte(8'h1C);
      exp_q.push_back(32'h8000_001C);
      while (exp_q.size() > 0) begin
         read_event(d);
         checks++;
         if (d !== exp_q[0]) begin failures++; $display("FAIL reset_mid_event got=%h exp=%h", d, exp_q[0]); end
         void'(exp_q.pop_front());
      end
      read_status(d);
      checks++;
      if (d !== 32'h0000_0001) begin failures++; $display("FAIL reset_mid_empty got=%h exp=00000001", d); end
      send_byte(8'hFA);
      exp_q.push_back(32'h8000_04FA);
      while (exp_q.size() > 0) begin
         read_event(d);
         checks++;
         if (d !== exp_q[0]) begin failures++; $display("FAIL ctrl_event got=%h exp=%h", d, exp_q[0]); end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_pause();
      logic [31:0] d;
      logic [7:0]  seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      foreach (seq[i]) send_byte(seq[i]);
`ifdef PS2KEY_PAUSE_FILTER_EN
      exp_q.push_back(32'h8000_01E1);
`else
      exp_q.push_back(32'h8000_00E1);
      exp_q.push_back(32'h8000_0014);
      exp_q.push_back(32'h8000_0077);
      exp_q.push_back(32'h8000_00E1);
      exp_q.push_back(32'h8000_0214);
      exp_q.push_back(32'h8000_0277);
`endif
      while (exp_q.size() > 0) begin
         read_event(d);
         checks++;
         if (d !== exp_q[0]) begin failures++; $display("FAIL pause_event got=%h exp=%h", d, exp_q[0]); end
         void'(exp_q.pop_front());
      end
      read_status(d);
      checks++;
      if (d !== 32'h0000_0001) begin failures++; $display("FAIL pause_empty got=%h exp=00000001", d); end
   endtask

   task automatic test_flush();
      logic [31:0] d;
      send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
      send_byte(8'hE0);
      write_ctrl(32'h8000_0000);
      read_status(d);
      checks++;
      if (d !== 32'h0000_0001) begin failures++; $display("FAIL flush_status got=%h exp=00000001", d); end
      send_byte(8'h1C);
      exp_q.push_back(32'h8000_001C);
      while (exp_q.size() > 0) begin
         read_event(d);
         checks++;
         if (d !== exp_q[0]) begin failures++; $display("FAIL flush_event got=%h exp=%h", d, exp_q[0]); end
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ext_break();
      test_overflow();
      test_pop_push_full();
      test_reset_mid();
      test_pause();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
